// File: rtl/dac_spi_output.sv
// Final stage after the convolution filter: converts each 12-bit signed sample to offset binary
// and sends it as a 16-bit SPI frame to an MCP4921-style DAC, followed by an LDAC latch pulse.
module dac_spi_output #(
  parameter int         CLK_DIV     = 4,
  parameter logic [3:0] CONFIG_BITS = 4'b0011,
  parameter int         LDAC_PULSE  = 2
) (
  input  logic        inClk,
  input  logic        inResetN,
  input  logic [11:0] inSample,
  input  logic        inSampleReady,
  output logic        outDacCsN,
  output logic        outDacSclk,
  output logic        outDacMosi,
  output logic        outDacLdacN,
  output logic        outBusy,
  output logic        outOverrun,
  output logic [7:0]  outDropCount
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_CSHOLD,
    ST_LDAC
  } state_e;

  localparam int CNT_MAX = (CLK_DIV > LDAC_PULSE) ? CLK_DIV : LDAC_PULSE;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] LDAC_LOAD = CNT_W'(LDAC_PULSE - 1);

  function automatic logic [15:0] build_frame(input logic [11:0] sample);
    // Inverting the sign bit maps -2048..2047 onto 0..4095.
    return {CONFIG_BITS, ~sample[11], sample[10:0]};
  endfunction

  logic             sync1_q, sync2_q, prev_q;
  logic             strobe_rise;

  logic             pend_valid_q, pend_valid_d;
  logic [11:0]      pend_data_q, pend_data_d;
  logic             overrun_q, overrun_d;
  logic [7:0]       drop_q, drop_d;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_q, bit_d;
  logic             phase_hi_q, phase_hi_d;
  logic [15:0]      shift_q, shift_d;

  logic             cs_n_q, cs_n_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             ldac_n_q, ldac_n_d;
  logic             busy_q, busy_d;

  logic             load;
  logic [11:0]      load_data;
  logic             cnt_done;

  // The synchronizer and edge history reset high so a strobe already asserted at reset
  // release is not mistaken for a new sample.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge inClk or negedge inResetN) begin
    if (!inResetN) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= inSampleReady;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign strobe_rise = sync2_q & ~prev_q;
  assign load        = (state_q == ST_IDLE) && pend_valid_q;
  // A sample captured in the load cycle bypasses the pending register.
  assign load_data   = strobe_rise ? inSample : pend_data_q;
  assign cnt_done    = (cnt_q == '0);

  // Pending buffer, overrun pulse and saturating drop counter.
  // NOTE: each always_comb assigns defaults to all its outputs first so no latch is inferred.
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    overrun_d    = 1'b0;
    drop_d       = drop_q;
    if (strobe_rise) begin
      pend_data_d  = inSample;
      pend_valid_d = 1'b1;
      if (pend_valid_q) begin
        overrun_d = 1'b1;
        if (drop_q != 8'hFF) begin
          drop_d = drop_q + 8'd1;
        end
      end
    end
    if (load) begin
      pend_valid_d = 1'b0;
    end
  end

  always_ff @(posedge inClk or negedge inResetN) begin
    if (!inResetN) begin
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      overrun_q    <= 1'b0;
      drop_q       <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      overrun_q    <= overrun_d;
      drop_q       <= drop_d;
    end
  end

  // Frame sequencer: state register.
  always_ff @(posedge inClk or negedge inResetN) begin
    if (!inResetN) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      phase_hi_q <= 1'b0;
      shift_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      phase_hi_q <= phase_hi_d;
      shift_q    <= shift_d;
    end
  end

  // Frame sequencer: next state. cnt_q counts down the cycles left in the current phase.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    phase_hi_d = phase_hi_q;
    shift_d    = shift_q;
    unique case (state_q)
      ST_IDLE: begin
        if (load) begin
          state_d = ST_SETUP;
          cnt_d   = DIV_LOAD;
          shift_d = build_frame(load_data);
        end
      end
      ST_SETUP: begin
        if (cnt_done) begin
          state_d    = ST_SHIFT;
          cnt_d      = DIV_LOAD;
          bit_d      = 4'd15;
          phase_hi_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_SHIFT: begin
        if (!cnt_done) begin
          cnt_d = cnt_q - 1'b1;
        end else if (phase_hi_q) begin
          // SCLK falls here, so MOSI advances and is settled long before the next rise.
          phase_hi_d = 1'b0;
          cnt_d      = DIV_LOAD;
          shift_d    = {shift_q[14:0], 1'b0};
        end else if (bit_q == 4'd0) begin
          state_d = ST_CSHOLD;
          cnt_d   = DIV_LOAD;
        end else begin
          bit_d      = bit_q - 4'd1;
          phase_hi_d = 1'b1;
          cnt_d      = DIV_LOAD;
        end
      end
      ST_CSHOLD: begin
        if (cnt_done) begin
          state_d = ST_LDAC;
          cnt_d   = LDAC_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_LDAC: begin
        if (cnt_done) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Frame sequencer: outputs, decoded from the next state and registered so the pins are glitch-free.
  always_comb begin
    cs_n_d   = 1'b1;
    sclk_d   = 1'b0;
    mosi_d   = 1'b0;
    ldac_n_d = 1'b1;
    busy_d   = (state_d != ST_IDLE);
    unique case (state_d)
      ST_SETUP: begin
        cs_n_d = 1'b0;
        mosi_d = shift_d[15];
      end
      ST_SHIFT: begin
        cs_n_d = 1'b0;
        sclk_d = phase_hi_d;
        mosi_d = shift_d[15];
      end
      ST_LDAC: begin
        ldac_n_d = 1'b0;
      end
      default: begin
        cs_n_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge inClk or negedge inResetN) begin
    if (!inResetN) begin
      cs_n_q   <= 1'b1;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      ldac_n_q <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      cs_n_q   <= cs_n_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      ldac_n_q <= ldac_n_d;
      busy_q   <= busy_d;
    end
  end

  assign outDacCsN    = cs_n_q;
  assign outDacSclk   = sclk_q;
  assign outDacMosi   = mosi_q;
  assign outDacLdacN  = ldac_n_q;
  assign outBusy      = busy_q;
  assign outOverrun   = overrun_q;
  assign outDropCount = drop_q;

endmodule
